// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the wishbone initiator
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} wb_state_e;

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  function automatic int tmo_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// rtl/wb_initiator_if.sv - request/response streams plus wishbone bus of the initiator
interface wb_initiator_if;
  import wb_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [WB_ADDR_W-1:0] req_addr;
  logic [WB_DATA_W-1:0] req_data;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WB_DATA_W-1:0] rsp_data;
  logic                 rsp_err;

  logic                 o_wb_cyc;
  logic                 o_wb_stb;
  logic                 o_wb_we;
  logic [WB_ADDR_W-1:0] o_wb_addr;
  logic [WB_DATA_W-1:0] o_wb_data;
  logic                 i_wb_ack;
  logic                 i_wb_stall;
  logic [WB_DATA_W-1:0] i_wb_data;

  modport master (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_stall, i_wb_data
  );

endinterface

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding wishbone pipelined initiator with timeout
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit RSP_ON_WRITE   = 1'b1
) (
  input logic             clk,
  input logic             reset,
  wb_initiator_if.master  bus
);

  localparam int             CNT_W    = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e            state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [WB_ADDR_W-1:0] addr_q, addr_d;
  logic [WB_DATA_W-1:0] wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WB_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_hit;
  logic                 tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    ack_hit     = 1'b0;

    // An ack only counts once the strobe has been accepted (stall low).
    if (state_q == REQ) begin
      ack_hit = bus.i_wb_ack && !bus.i_wb_stall;
    end else if (state_q == WAIT) begin
      ack_hit = bus.i_wb_ack;
    end
    tmo_hit = ((state_q == REQ) || (state_q == WAIT)) && !ack_hit && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_we ? bus.req_data : '0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        if (ack_hit || tmo_hit) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          rsp_err_d  = tmo_hit;
          rsp_data_d = (ack_hit && !we_q) ? bus.i_wb_data : '0;
          if (ack_hit && we_q && !RSP_ON_WRITE) begin
            state_d = IDLE;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((state_q == REQ) && !bus.i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.o_wb_cyc  = cyc_q;
  assign bus.o_wb_stb  = stb_q;
  assign bus.o_wb_we   = we_q;
  assign bus.o_wb_addr = addr_q;
  assign bus.o_wb_data = wdata_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - randomized self-checking bench for wb_initiator
module tb_wb_initiator;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  wb_initiator_if bus();
  wb_initiator_if bus2();

  wb_initiator #(.TIMEOUT_CYCLES(16), .RSP_ON_WRITE(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  wb_initiator #(.TIMEOUT_CYCLES(4), .RSP_ON_WRITE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // Responder: buttons/LEDs at addr 1, scratch registers at 0..15, nothing above.
  int          stall_req = 0;
  bit          comb_mode = 1'b0;
  logic [2:0]  buttons = 3'b000;
  logic [7:0]  leds;
  logic [31:0] mem [16];
  int          stb_seen;
  logic        ack_q;
  logic [31:0] rdat_q;
  logic [31:0] rd_now;
  logic        mapped;
  logic        accept;

  assign mapped = bus.o_wb_addr < 32'd16;
  assign accept = bus.o_wb_cyc && bus.o_wb_stb && (stb_seen >= stall_req);
  always_comb rd_now = (bus.o_wb_addr == 32'd1) ? {29'd0, buttons} : mem[bus.o_wb_addr[3:0]];

  assign bus.i_wb_stall = bus.o_wb_stb && (stb_seen < stall_req);
  assign bus.i_wb_ack   = comb_mode ? (accept && mapped) : ack_q;
  assign bus.i_wb_data  = comb_mode ? rd_now : rdat_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      leds     <= 8'd0;
      stb_seen <= 0;
      ack_q    <= 1'b0;
      rdat_q   <= 32'd0;
    end else begin
      stb_seen <= bus.o_wb_stb ? stb_seen + 1 : 0;
      ack_q    <= 1'b0;
      if (accept && mapped) begin
        ack_q  <= !comb_mode;
        rdat_q <= bus.o_wb_we ? 32'hDEAD_BEEF : rd_now;
        if (bus.o_wb_we) begin
          if (bus.o_wb_addr == 32'd1) leds <= bus.o_wb_data[7:0];
          else mem[bus.o_wb_addr[3:0]] <= bus.o_wb_data;
        end
      end
    end
  end

  logic [31:0] ref_mem [16];
  logic [7:0]  ref_leds = 8'd0;

  // Issues one request, follows it to its response, holds rsp_ready low for
  // 'hold' cycles, then completes the handshake. ok drops on any protocol slip.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input int stall, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int stb_n, output logic cyc_rsp, output bit ok);
    ok = 1'b1; stb_n = 0; lat = 0;
    stall_req = stall;
    bus.req_we = we; bus.req_addr = addr; bus.req_data = data; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.o_wb_stb) begin
        stb_n++;
        if (bus.o_wb_addr !== addr || bus.o_wb_we !== we || bus.o_wb_data !== (we ? data : 32'd0))
          ok = 1'b0;
      end
      if (bus.req_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.rsp_data; err = bus.rsp_err; cyc_rsp = bus.o_wb_cyc;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid || bus.rsp_data !== rdata || bus.rsp_err !== err || bus.req_ready) ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_total++;
    if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.rsp_valid, bus.rsp_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.rsp_valid, bus.rsp_err});
    else n_pass++;
    n_total++;
    if ({bus.o_wb_addr, bus.o_wb_data, bus.rsp_data} !== 96'd0)
      $display("FAIL reset_data: got %h/%h/%h expected zeros", bus.o_wb_addr, bus.o_wb_data, bus.rsp_data);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_write_leds();
    logic [31:0] rd; logic er, cr; int lat, sn; bit ok;
    do_txn(1'b1, 32'd1, 32'h0000_00F0, 0, 0, rd, er, lat, sn, cr, ok);
    ref_leds = 8'hF0;
    n_total++;
    if (sn !== 1 || lat !== 2 || ok !== 1'b1)
      $display("FAIL wr_timing: got stb=%0d lat=%0d ok=%0d expected 1/2/1", sn, lat, ok);
    else n_pass++;
    n_total++;
    if ({er, rd} !== 33'd0) $display("FAIL wr_rsp: got err=%b data=%h expected 0/0", er, rd);
    else n_pass++;
    n_total++;
    if (leds !== 8'hF0) $display("FAIL wr_leds: got %h expected f0", leds);
    else n_pass++;
  endtask

  task automatic test_read_buttons();
    logic [31:0] rd; logic er, cr; int lat, sn; bit ok;
    buttons = 3'b101;
    do_txn(1'b0, 32'd1, 32'hFFFF_FFFF, 0, 0, rd, er, lat, sn, cr, ok);
    n_total++;
    if (rd !== 32'h5 || er !== 1'b0) $display("FAIL rd_buttons: got %h err=%b expected 5/0", rd, er);
    else n_pass++;
    n_total++;
    if (cr !== 1'b0 || lat !== 2 || ok !== 1'b1)
      $display("FAIL rd_timing: got cyc=%b lat=%0d ok=%0d expected 0/2/1", cr, lat, ok);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er, cr; int lat, sn; bit ok; int extra;
    do_txn(1'b1, 32'd3, 32'h1357_9BDF, 3, 0, rd, er, lat, sn, cr, ok);
    ref_mem[3] = 32'h1357_9BDF;
    stall_req = 0;
    n_total++;
    if (sn !== 4 || lat !== 5 || ok !== 1'b1)
      $display("FAIL stall_timing: got stb=%0d lat=%0d ok=%0d expected 4/5/1", sn, lat, ok);
    else n_pass++;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || bus.o_wb_cyc) extra++;
    end
    n_total++;
    if (extra !== 0 || mem[3] !== ref_mem[3])
      $display("FAIL stall_single: got extra=%0d mem=%h expected 0/%h", extra, mem[3], ref_mem[3]);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, cr; int lat, sn; bit ok;
    do_txn(1'b0, 32'h20, 32'd0, 0, 0, rd, er, lat, sn, cr, ok);
    n_total++;
    if (lat !== 16 || cr !== 1'b0 || ok !== 1'b1)
      $display("FAIL tmo_timing: got lat=%0d cyc=%b ok=%0d expected 16/0/1", lat, cr, ok);
    else n_pass++;
    n_total++;
    if (er !== 1'b1 || rd !== 32'd0) $display("FAIL tmo_rsp: got err=%b data=%h expected 1/0", er, rd);
    else n_pass++;
  endtask

  task automatic test_comb_ack();
    logic [31:0] rd; logic er, cr; int lat, sn; bit ok;
    comb_mode = 1'b1;
    do_txn(1'b1, 32'd2, 32'h2222_0002, 0, 0, rd, er, lat, sn, cr, ok);
    ref_mem[2] = 32'h2222_0002;
    n_total++;
    if (lat !== 1 || rd !== 32'd0 || ok !== 1'b1)
      $display("FAIL comb_wr: got lat=%0d data=%h ok=%0d expected 1/0/1", lat, rd, ok);
    else n_pass++;
    do_txn(1'b0, 32'd2, 32'd0, 0, 0, rd, er, lat, sn, cr, ok);
    n_total++;
    if (lat !== 1 || rd !== ref_mem[2] || er !== 1'b0)
      $display("FAIL comb_rd: got lat=%0d data=%h expected 1/%h", lat, rd, ref_mem[2]);
    else n_pass++;
    comb_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; bit stable; int g;
    stall_req = 0;
    bus.req_we = 1'b0; bus.req_addr = 32'd2; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.rsp_valid && g < 40) begin @(posedge clk); #1; g++; end
    d0 = bus.rsp_data;
    n_total++;
    if (g !== 2 || d0 !== ref_mem[2])
      $display("FAIL bp_first: got lat=%0d data=%h expected 2/%h", g, d0, ref_mem[2]);
    else n_pass++;
    bus.req_we = 1'b1; bus.req_addr = 32'd4; bus.req_data = 32'hA5A5_0004; bus.req_valid = 1'b1;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_err || bus.req_ready || bus.o_wb_cyc)
        stable = 1'b0;
    end
    n_total++;
    if (stable !== 1'b1) $display("FAIL bp_hold: got stable=%0d expected 1", stable);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_total++;
    if ({bus.rsp_valid, bus.req_ready, bus.o_wb_cyc} !== 3'b010)
      $display("FAIL bp_handshake: got %b expected 010", {bus.rsp_valid, bus.req_ready, bus.o_wb_cyc});
    else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ref_mem[4] = 32'hA5A5_0004;
    n_total++;
    if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_addr} !== {2'b11, 32'd4})
      $display("FAIL bp_next_accept: got cyc=%b stb=%b addr=%h expected 1/1/4",
               bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_addr);
    else n_pass++;
    g = 0;
    while (!bus.rsp_valid && g < 40) begin @(posedge clk); #1; g++; end
    n_total++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 32'd0})
      $display("FAIL bp_next_rsp: got v=%b err=%b data=%h expected 1/0/0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_d; logic er, cr, we, exp_err; int lat, sn, a, st, hd, exp_lat; bit ok;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1)); a = $urandom_range(0, 19); d = $urandom;
      st = $urandom_range(0, 2); hd = $urandom_range(0, 2);
      buttons = 3'($urandom_range(0, 7));
      if (a >= 16) begin
        exp_err = 1'b1; exp_d = 32'd0; exp_lat = 16;
      end else begin
        exp_err = 1'b0; exp_lat = 2 + st;
        exp_d = we ? 32'd0 : ((a == 1) ? {29'd0, buttons} : ref_mem[a]);
        if (we) begin
          if (a == 1) ref_leds = d[7:0];
          else ref_mem[a] = d;
        end
      end
      do_txn(we, 32'(a), d, st, hd, rd, er, lat, sn, cr, ok);
      n_total++;
      if (rd !== exp_d || er !== exp_err)
        $display("FAIL rand_rsp[%0d]: got %h err=%b expected %h err=%b", i, rd, er, exp_d, exp_err);
      else n_pass++;
      n_total++;
      if (lat !== exp_lat || cr !== 1'b0 || ok !== 1'b1)
        $display("FAIL rand_timing[%0d]: got lat=%0d cyc=%b ok=%0d expected %0d/0/1",
                 i, lat, cr, ok, exp_lat);
      else n_pass++;
    end
    stall_req = 0;
    n_total++;
    if (leds !== ref_leds) $display("FAIL rand_leds: got %h expected %h", leds, ref_leds);
    else n_pass++;
  endtask

  task automatic test_silent_write();
    int lat;
    bus2.req_we = 1'b1; bus2.req_addr = 32'd7; bus2.req_data = 32'h0000_1234; bus2.req_valid = 1'b1;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    @(posedge clk); #1;
    bus2.i_wb_ack = 1'b1;
    @(posedge clk); #1;
    bus2.i_wb_ack = 1'b0;
    n_total++;
    if ({bus2.rsp_valid, bus2.o_wb_cyc, bus2.req_ready} !== 3'b001)
      $display("FAIL silent_wr: got %b expected 001", {bus2.rsp_valid, bus2.o_wb_cyc, bus2.req_ready});
    else n_pass++;
    bus2.req_valid = 1'b1;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    lat = 0;
    while (!bus2.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_total++;
    if (lat !== 4 || bus2.rsp_err !== 1'b1 || bus2.rsp_data !== 32'd0)
      $display("FAIL silent_err: got lat=%0d err=%b data=%h expected 4/1/0", lat, bus2.rsp_err, bus2.rsp_data);
    else n_pass++;
    bus2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus2.rsp_ready = 1'b0;
    n_total++;
    if ({bus2.rsp_valid, bus2.req_ready} !== 2'b01)
      $display("FAIL silent_done: got %b expected 01", {bus2.rsp_valid, bus2.req_ready});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stale;
    stall_req = 0;
    bus.req_we = 1'b0; bus.req_addr = 32'h30; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b10)
      $display("FAIL mid_wait: got cyc/stb=%b expected 10", {bus.o_wb_cyc, bus.o_wb_stb});
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({bus.o_wb_cyc, bus.o_wb_stb, bus.rsp_valid} !== 3'b000)
      $display("FAIL mid_reset: got %b expected 000", {bus.o_wb_cyc, bus.o_wb_stb, bus.rsp_valid});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    @(posedge clk); #1;
    n_total++;
    if (bus.req_ready !== 1'b1) $display("FAIL mid_req_ready: got %b expected 1", bus.req_ready);
    else n_pass++;
    stale = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || bus.o_wb_cyc) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL mid_stale: got %0d busy cycles expected 0", stale);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0; bus.req_data = 32'd0;
    bus.rsp_ready = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'd0; bus2.req_data = 32'd0;
    bus2.rsp_ready = 1'b0; bus2.i_wb_ack = 1'b0; bus2.i_wb_stall = 1'b0; bus2.i_wb_data = 32'hCAFE_0000;
    test_reset();
    test_write_leds();
    test_read_buttons();
    test_stall();
    test_timeout();
    test_comb_ack();
    test_backpressure();
    test_random();
    test_silent_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Single-outstanding Wishbone pipelined-mode initiator (bus master).
- Turns a simple valid/ready request stream (read/write, address, data) into one Wishbone transaction and returns the result on a valid/ready response stream.
- Drives peripheral responders such as the buttons/LEDs register block from a local controller or test sequencer.
- Bounded per-transaction timeout so a missing or unmapped responder cannot hang the bus.

Parameters:
- TIMEOUT_CYCLES, 16, cycles from strobe assertion with no ack before the transaction is abandoned with an error; must be ≥2.
- RSP_ON_WRITE, 1, 1 = writes also produce a response beat (rsp_data=0); 0 = writes complete silently.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  target address
- req_data  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  read data (0 for writes and errors)
- rsp_err  out  1  transaction timed out
- o_wb_cyc  out  1  bus cycle active
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  32  address
- o_wb_data  out  32  write data
- i_wb_ack  in  1  responder completion
- i_wb_stall  in  1  responder cannot accept
- i_wb_data  in  32  read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs 0: o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, rsp_valid, rsp_data, rsp_err, timeout counter.
  - req_ready=1 after reset deasserts.
  - Reset mid-transaction drops cyc/stb in the same cycle; no response is produced for the aborted request.
- States: IDLE, REQ, WAIT, RESP. All outputs registered except req_ready = (state==IDLE).
- IDLE: on req_valid&&req_ready, latch we/addr/data, assert cyc=stb=1, drive o_wb_we/o_wb_addr; o_wb_data=req_data if write, else 0. Go to REQ, counter=0.
- REQ: stb held, addr/data/we stable while i_wb_stall=1.
  - On an edge with i_wb_stall=0 the request is accepted: stb←0.
  - If i_wb_ack is also 1 at that edge (combinational responder), go straight to RESP; otherwise go to WAIT.
  - i_wb_ack while i_wb_stall=1 is ignored.
- WAIT: cyc=1, stb=0. On i_wb_ack: cyc←0, capture rsp_data=i_wb_data for reads or 0 for writes, rsp_err=0, go to RESP.
- Timeout:
  - Counter increments every cycle in REQ and WAIT.
  - On the edge where counter==TIMEOUT_CYCLES-1 with no qualifying ack: cyc=stb←0, rsp_err=1, rsp_data=0, go to RESP.
  - An ack on the same edge wins; rsp_err=0.
  - Late acks arriving in RESP or IDLE are ignored.
- RESP: rsp_valid=1 held, rsp_data/rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready: rsp_valid←0, go to IDLE.
  - Write with RSP_ON_WRITE=0 and no error skips RESP: go directly to IDLE.
  - Errors always produce a response.
- Latency, zero-stall responder with registered ack: request accepted at edge E0 → stb high E0–E1 → ack sampled at E2 → rsp_valid high from E2. Next request is accepted at the edge after the response handshake.
- Back-to-back: no pipelining; one transaction outstanding. req_ready=0 from acceptance until return to IDLE.
- cyc never drops while stb=1, except on reset.

Decomposition:
- Shared package wb_pkg:
  - state enum {IDLE, REQ, WAIT, RESP}
  - WB_ADDR_W=32, WB_DATA_W=32
  - timeout counter width localparam $clog2(TIMEOUT_CYCLES+1).
- No sub-module required. The timeout counter stays inline; a separate wb_timeout counter module is acceptable if reused by other initiators.

Test Plan:
- Write 0x000000F0 to addr 1 against the buttons/LEDs responder, no stall → stb high exactly 1 cycle, o_wb_data=0xF0, rsp_valid 2 cycles after accept, rsp_err=0, leds=0xF0.
- Read addr 1 with buttons=3'b101 → rsp_data=0x00000005, rsp_err=0, cyc low when rsp_valid rises.
- Stall held 3 cycles during a write → addr/data/we stable for 4 strobe cycles, single acceptance, exactly one response.
- Read addr 0x20 (unmapped, no ack), TIMEOUT_CYCLES=16 → cyc drops 16 cycles after stb rose, rsp_err=1, rsp_data=0.
- rsp_ready low for 5 cycles → rsp_valid/rsp_data stable, req_ready=0 throughout, next request accepted only after handshake.
- Assert reset while in WAIT → cyc/stb/rsp_valid 0 in that cycle; after release req_ready=1 and no stale response appears.
